// File: rtl/pump_phase_ctrl.sv
// pump_phase_ctrl
//   Two-phase, non-overlapping clock generator for a charge pump with
//   comparator-based regulation. Each pump cycle runs PH1 -> DEAD1 -> PH2 ->
//   DEAD2. A new cycle starts only while pumping is requested and the
//   synchronized comparator reports the pumped node below target. A cycle that
//   is due but skipped because the node is already high sets a sticky flag.
//
// Ports
//   clk     : sole clock, rising edge
//   rst_n   : asynchronous active-low reset
//   en      : pumping request
//   div     : phase length minus one, in clk cycles
//   dead    : dead-time length in clk cycles (0 behaves as 1)
//   fb_hi   : asynchronous comparator output, 1 = node above target
//   clr     : synchronous clear of cnt and ovr
//   phi1    : phase-1 drive (registered)
//   phi2    : phase-2 drive (registered)
//   active  : high whenever the sequencer is not idle
//   cnt     : completed pump cycles, saturating
//   ovr     : sticky, at least one cycle was skipped because of fb_hi
module pump_phase_ctrl #(
    parameter int DIV_W  = 8,
    parameter int DEAD_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DIV_W-1:0]  div,
    input  logic [DEAD_W-1:0] dead,
    input  logic              fb_hi,
    input  logic              clr,
    output logic              phi1,
    output logic              phi2,
    output logic              active,
    output logic [CNT_W-1:0]  cnt,
    output logic              ovr
);

    localparam int TMR_W = (DIV_W > DEAD_W) ? DIV_W : DEAD_W;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PH1   = 3'd1,
        DEAD1 = 3'd2,
        PH2   = 3'd3,
        DEAD2 = 3'd4
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [TMR_W-1:0]  tmr;
    logic [DIV_W-1:0]  div_l;
    logic [DEAD_W-1:0] dead_l;
    logic [DEAD_W-1:0] dead_end;
    logic              fb_m;
    logic              fb_s;
    logic              ph_last;
    logic              dead_last;
    logic              go;
    logic              phi1_nxt;
    logic              phi2_nxt;
    logic              active_nxt;
    logic              inc;
    logic              ovr_set;

    // Two-flop synchronizer for the asynchronous comparator output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fb_m <= 1'b0;
            fb_s <= 1'b0;
        end else begin
            fb_m <= fb_hi;
            fb_s <= fb_m;
        end
    end

    // tmr counts cycles spent in the current state, starting at 0 on entry.
    // A dead time of 0 is stretched to one cycle so the phases never touch.
    always_comb begin
        dead_end  = (dead_l == '0) ? '0 : dead_l - DEAD_W'(1);
        ph_last   = (tmr == TMR_W'(div_l));
        dead_last = (tmr == TMR_W'(dead_end));
        go        = en && !fb_s;
    end

    // State register, in-state timer and per-cycle latched settings.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            tmr    <= '0;
            div_l  <= '0;
            dead_l <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state || state == IDLE) begin
                tmr <= '0;
            end else begin
                tmr <= tmr + TMR_W'(1);
            end
            // Settings are sampled once per cycle so mid-cycle edits wait.
            if (state_nxt == PH1 && state != PH1) begin
                div_l  <= div;
                dead_l <= dead;
            end
        end
    end

    // Next-state logic: a started cycle always runs to the end of DEAD2.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (go)        state_nxt = PH1;
            PH1:     if (ph_last)   state_nxt = DEAD1;
            DEAD1:   if (dead_last) state_nxt = PH2;
            PH2:     if (ph_last)   state_nxt = DEAD2;
            DEAD2:   if (dead_last) state_nxt = go ? PH1 : IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Output logic: drives are decoded from the next state and registered,
    // so phi1/phi2 line up exactly with PH1/PH2.
    always_comb begin
        phi1_nxt   = (state_nxt == PH1);
        phi2_nxt   = (state_nxt == PH2);
        active_nxt = (state_nxt != IDLE);
        inc        = (state == PH2) && ph_last;
        ovr_set    = fb_s && (((state == IDLE) && en) ||
                              ((state == DEAD2) && dead_last));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phi1   <= 1'b0;
            phi2   <= 1'b0;
            active <= 1'b0;
            cnt    <= '0;
            ovr    <= 1'b0;
        end else begin
            phi1   <= phi1_nxt;
            phi2   <= phi2_nxt;
            active <= active_nxt;
            if (clr) begin
                cnt <= '0;
            end else if (inc && cnt != '1) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (clr) begin
                ovr <= 1'b0;
            end else if (ovr_set) begin
                ovr <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pump_phase_ctrl.sv
// Testbench for pump_phase_ctrl (CNT_W reduced to 4 so saturation is reachable).
// Expected per-cycle output vectors {phi1,phi2,active,cnt,ovr} are derived from
// the pump timing formulas and queued as stimulus is applied; each scenario
// pops and compares them as the DUT produces output.
module tb_pump_phase_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [7:0] div;
    logic [3:0] dead;
    logic       fb_hi;
    logic       clr;
    logic       phi1;
    logic       phi2;
    logic       active;
    logic [3:0] cnt;
    logic       ovr;

    int checks   = 0;
    int failures = 0;
    logic [7:0] q[$];

    always #5 clk = ~clk;

    pump_phase_ctrl #(.DIV_W(8), .DEAD_W(4), .CNT_W(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .div    (div),
        .dead   (dead),
        .fb_hi  (fb_hi),
        .clr    (clr),
        .phi1   (phi1),
        .phi2   (phi2),
        .active (active),
        .cnt    (cnt),
        .ovr    (ovr)
    );

    function automatic logic [7:0] obs();
        return {phi1, phi2, active, cnt, ovr};
    endfunction

    // Queue n cycles of a continuously running pump starting at first PH1 cycle.
    task automatic push_run(input int d, input int dd, input int n, input int c0, input logic ov);
        int dl, p, pos, c;
        logic p1, p2;
        logic [3:0] cv;
        dl = (dd == 0) ? 1 : dd;
        p  = 2 * (d + 1) + 2 * dl;
        for (int j = 0; j < n; j++) begin
            pos = j % p;
            p1  = (pos < d + 1);
            p2  = (pos >= d + 1 + dl) && (pos < 2 * (d + 1) + dl);
            c   = c0 + (j + 1) / p;
            if (c > 15) c = 15;
            cv  = c[3:0];
            q.push_back({p1, p2, 1'b1, cv, ov});
        end
    endtask

    task automatic push_idle(input int n, input logic [3:0] c, input logic ov);
        for (int j = 0; j < n; j++) q.push_back({3'b000, c, ov});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; en = 1'b0; fb_hi = 1'b0; clr = 1'b0; div = 8'd0; dead = 4'd0;
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
    endtask

    task automatic test_reset();
        logic [7:0] e;
        rst_n = 1'b0; en = 1'b0; fb_hi = 1'b1; clr = 1'b0; div = 8'd0; dead = 4'd0;
        #12;
        q.push_back(8'h00);
        e = q.pop_front();
        checks++;
        if (obs() !== e) begin
            failures++;
            $display("FAIL reset_hold got=%b exp=%b", obs(), e);
        end
        @(negedge clk) rst_n = 1'b1;
        push_idle(3, 4'd0, 1'b0);
        push_idle(3, 4'd0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (i == 2) en = 1'b1;
            @(negedge clk);
            e = q.pop_front();
            checks++;
            if (obs() !== e) begin
                failures++;
                $display("FAIL reset_idle_ovr cyc=%0d got=%b exp=%b", i, obs(), e);
            end
        end
    endtask

    task automatic test_basic();
        logic [7:0] e;
        do_reset();
        div = 8'd2; dead = 4'd1;
        push_run(2, 1, 24, 0, 1'b0);
        @(posedge clk); #1 en = 1'b1;
        for (int i = 0; i < 24; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            e = q.pop_front();
            checks++;
            if (obs() !== e) begin
                failures++;
                $display("FAIL basic cyc=%0d got=%b exp=%b", i, obs(), e);
            end
        end
    endtask

    task automatic test_min_timing();
        logic [7:0] e;
        do_reset();
        div = 8'd0; dead = 4'd0;
        push_run(0, 0, 16, 0, 1'b0);
        @(posedge clk); #1 en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            e = q.pop_front();
            checks++;
            if (obs() !== e || (phi1 && phi2)) begin
                failures++;
                $display("FAIL min_timing cyc=%0d got=%b exp=%b", i, obs(), e);
            end
        end
    endtask

    task automatic test_feedback_clr();
        logic [7:0] e;
        do_reset();
        div = 8'd2; dead = 4'd1;
        push_run(2, 1, 8, 0, 1'b0);
        push_idle(5, 4'd1, 1'b1);
        push_run(2, 1, 7, 1, 1'b1);
        q.push_back({3'b001, 4'd0, 1'b0});
        @(posedge clk); #1 en = 1'b1;
        for (int i = 0; i < 21; i++) begin
            @(posedge clk); #1;
            if (i == 0)  fb_hi = 1'b1;
            if (i == 10) fb_hi = 1'b0;
            if (i == 19) clr = 1'b1;
            if (i == 20) clr = 1'b0;
            @(negedge clk);
            e = q.pop_front();
            checks++;
            if (obs() !== e) begin
                failures++;
                $display("FAIL feedback_clr cyc=%0d got=%b exp=%b", i, obs(), e);
            end
        end
    endtask

    task automatic test_en_div_change();
        logic [7:0] e;
        do_reset();
        div = 8'd2; dead = 4'd1;
        push_run(2, 1, 8, 0, 1'b0);
        push_idle(2, 4'd1, 1'b0);
        push_run(5, 1, 14, 1, 1'b0);
        @(posedge clk); #1 en = 1'b1;
        for (int i = 0; i < 24; i++) begin
            @(posedge clk); #1;
            if (i == 1) div = 8'd5;
            if (i == 5) en = 1'b0;
            if (i == 9) en = 1'b1;
            @(negedge clk);
            e = q.pop_front();
            checks++;
            if (obs() !== e) begin
                failures++;
                $display("FAIL en_div_change cyc=%0d got=%b exp=%b", i, obs(), e);
            end
        end
    endtask

    task automatic test_saturation();
        logic [7:0] e;
        int c;
        logic [3:0] cv;
        do_reset();
        div = 8'd0; dead = 4'd0;
        for (int j = 0; j < 80; j++) begin
            c = (j < 71) ? (j + 1) / 4 : (j + 1) / 4 - 18;
            if (c > 15) c = 15;
            cv = c[3:0];
            q.push_back({(j % 4 == 0), (j % 4 == 2), 1'b1, cv, 1'b0});
        end
        @(posedge clk); #1 en = 1'b1;
        for (int j = 0; j < 80; j++) begin
            @(posedge clk); #1;
            if (j == 70) clr = 1'b1;
            if (j == 71) clr = 1'b0;
            @(negedge clk);
            e = q.pop_front();
            checks++;
            if (obs() !== e) begin
                failures++;
                $display("FAIL saturation cyc=%0d got=%b exp=%b", j, obs(), e);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] e;
        do_reset();
        div = 8'd2; dead = 4'd1;
        push_run(2, 1, 9, 0, 1'b0);
        q.push_back(8'h00);
        push_run(2, 1, 8, 0, 1'b0);
        @(posedge clk); #1 en = 1'b1;
        for (int i = 0; i < 18; i++) begin
            @(posedge clk);
            if (i == 9) begin
                #2 rst_n = 1'b0;
                #1;
                e = q.pop_front();
                checks++;
                if (obs() !== e) begin
                    failures++;
                    $display("FAIL async_reset_drop got=%b exp=%b", obs(), e);
                end
                #1 rst_n = 1'b1;
            end else begin
                #1;
                @(negedge clk);
                e = q.pop_front();
                checks++;
                if (obs() !== e) begin
                    failures++;
                    $display("FAIL async_reset_restart cyc=%0d got=%b exp=%b", i, obs(), e);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_min_timing();
        test_feedback_clr();
        test_en_div_change();
        test_saturation();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
